axi_sram_tester_master: RTL and testbench
=========================================

Name: axi_sram_tester_master

Overview:
Parametrised AXI-Lite master that exercises an SRAM-backed slave (typically axi_sram_controller) over a configurable address window. It runs four data patterns per iteration with pipelined reads, up to MAX_OUTSTANDING in flight. It compares every read beat against the expected value, counts errors and captures the first failure. It can run once or continuously, and can either halt on the first error or keep going.

Parameters:
ADDR_BITS, 20, AXI address width.
DATA_BITS, 16, AXI data width (multiple of 8).
ADDR_MIN, 0, first tested address (inclusive).
ADDR_MAX, (1<<ADDR_BITS)-1, last tested address (inclusive); ADDR_MIN <= ADDR_MAX.
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered reads; power of 2, >= 1.
ERR_BITS, 16, width of error_count and iter_count.

Ports:
axi_clk  in  1  clock.
axi_resetn  in  1  synchronous active-low reset.
start  in  1  pulse: begin a run (ignored unless IDLE or DONE).
continuous  in  1  sampled at start: 1 = loop iterations until reset.
halt_on_error  in  1  sampled at start: 1 = stop issuing on the first mismatch.
busy  out  1  run in progress.
done  out  1  run finished; held until the next start.
test_pass  out  1  no mismatch since start.
error_count  out  ERR_BITS  mismatches since start (saturating).
iter_count  out  ERR_BITS  completed 4-pattern iterations (wraps).
fail_addr  out  ADDR_BITS  address of first mismatch.
fail_data  out  DATA_BITS  read data of first mismatch.
fail_expected  out  DATA_BITS  expected data of first mismatch.
pattern_idx  out  2  current pattern.
axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r*  -  -  standard AXI-Lite master channels (awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready).

Behaviour:
- Reset (axi_resetn=0 at a clock edge):
  - State goes to IDLE.
  - All valids go to 0; bready and rready go to 0.
  - busy=0, done=0, test_pass=1.
  - error_count, iter_count, fail_* and pattern_idx go to 0.
  - Outstanding counter and expected FIFO are cleared.
  - Reset mid-transaction abandons it; no further handshakes complete.
- Out of reset, bready=1 and rready=1 at all times.
- axi_wstrb is all ones.
- Pattern as a function of address a and pattern index p:
  - p=0: a zero-extended or truncated to DATA_BITS.
  - p=1: bitwise NOT of the p=0 value.
  - p=2: 0x55..55 for even a, 0xAA..AA for odd a.
  - p=3: bitwise NOT of the p=2 value.
- States:
  - IDLE: on start, latch the mode inputs, clear error_count, iter_count, fail_* and test_pass, set p=0 and busy=1, then go to WRITE.
  - WRITE: for each address from ADDR_MIN to ADDR_MAX:
    - Assert awvalid and wvalid together with awaddr=a and wdata=pattern.
    - Each valid drops independently on its own handshake.
    - Wait for bvalid (bresp ignored) before the next write; only one write is ever in flight.
    - After the B for ADDR_MAX, go to READ.
  - READ: for each address from ADDR_MIN to ADDR_MAX:
    - Issue arvalid only while outstanding < MAX_OUTSTANDING.
    - On the AR handshake, push the expected value and the address into the FIFO, and increment outstanding.
    - Back-to-back ARs are allowed (one per cycle).
    - After the AR for ADDR_MAX is accepted, go to DRAIN.
  - DRAIN: wait until outstanding=0.
    - If p<3: p++ and go to WRITE.
    - Else: iter_count++. Go to WRITE with p=0 if continuous, otherwise go to DONE.
  - DONE: busy=0, done=1. A start restarts as from IDLE.
- R handshake:
  - Pop the FIFO, decrement outstanding, and compare rdata against the expected value.
  - An R handshake and an AR handshake in the same cycle leave outstanding unchanged.
  - rresp is ignored.
- Mismatch handling:
  - error_count++, saturating at all-ones.
  - If test_pass was 1, capture fail_addr, fail_data and fail_expected, then set test_pass=0 on the next cycle.
  - If halt_on_error: issue no new AW/AR (a valid already asserted is held until its handshake), finish draining outstanding reads (still counted), then go to DONE.
- Outputs are registered; the first AW/W is valid 1 cycle after start is sampled.
- Single-address window (ADDR_MIN=ADDR_MAX): each phase is one transaction.
- The FIFO never overflows, by the outstanding limit.

Test Plan:
1. ADDR_MIN=0, ADDR_MAX=7, ideal memory model, continuous=0, start pulse -> 32 writes and 32 reads with pattern values per the formula; done=1, test_pass=1, error_count=0, iter_count=1.
2. Model corrupts the read of addr 5 in p=1 (returns 0x0000 instead of 0xFFFA), halt_on_error=0 -> error_count=1, fail_addr=5, fail_data=0x0000, fail_expected=0xFFFA, test_pass=0, run completes with iter_count=1.
3. Same corruption with halt_on_error=1 -> no AR issued after the mismatch apart from ones already asserted; outstanding reaches 0; done=1 with iter_count=0.
4. MAX_OUTSTANDING=4, slave delays rvalid 10 cycles and holds arready=1 -> at most 4 AR handshakes without R; a 5th arvalid appears only after an R handshake; all data correct.
5. Random awready/wready/arready/bvalid stalls -> results identical to scenario 1; awvalid and wvalid never drop before their handshakes.
6. continuous=1, deassert axi_resetn mid-READ for 1 cycle -> all valids 0 and counters 0 on the next cycle; a new start gives a clean pass.

Source files
------------

// File: rtl/axi_sram_tester_master_if.sv
// AXI-Lite bus bundle between the SRAM tester master and the slave under test.
//   master modport : drives AW/W/AR address, data, valids and the B/R readies
//   slave modport  : drives the AW/W/AR readies and the B/R responses
interface axi_sram_tester_master_if #(
   parameter int ADDR_BITS = 20,
   parameter int DATA_BITS = 16
);
   logic [ADDR_BITS-1:0]   awaddr;
   logic                   awvalid;
   logic                   awready;
   logic [DATA_BITS-1:0]   wdata;
   logic [DATA_BITS/8-1:0] wstrb;
   logic                   wvalid;
   logic                   wready;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;
   logic [ADDR_BITS-1:0]   araddr;
   logic                   arvalid;
   logic                   arready;
   logic [DATA_BITS-1:0]   rdata;
   logic [1:0]             rresp;
   logic                   rvalid;
   logic                   rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_sram_tester_master.sv
// AXI-Lite master that writes four data patterns across [ADDR_MIN, ADDR_MAX],
// reads each back with up to MAX_OUTSTANDING reads in flight, and checks the data.
//   axi_clk, axi_resetn     : clock, synchronous active-low reset
//   start                   : pulse, begins a run from IDLE or DONE
//   continuous              : latched at start, loop iterations until reset
//   halt_on_error           : latched at start, stop issuing on first mismatch
//   busy, done, test_pass   : run status
//   error_count, iter_count : saturating mismatch count, wrapping iteration count
//   fail_addr/data/expected : first mismatch capture
//   pattern_idx             : current pattern (0..3)
//   axi                     : AXI-Lite master channels
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | out of reset, waiting for start
// S_WRITE | one write at a time, ADDR_MIN..ADDR_MAX, current pattern
// S_READ  | pipelined reads ADDR_MIN..ADDR_MAX, bounded by outstanding limit
// S_DRAIN | waiting for all outstanding reads; picks next pattern or ends
// S_DONE  | run finished, waiting for a new start
module axi_sram_tester_master #(
   parameter int                   ADDR_BITS       = 20,
   parameter int                   DATA_BITS       = 16,
   parameter logic [ADDR_BITS-1:0] ADDR_MIN        = '0,
   parameter logic [ADDR_BITS-1:0] ADDR_MAX        = '1,
   parameter int                   MAX_OUTSTANDING = 4,
   parameter int                   ERR_BITS        = 16
) (
   input  logic                 axi_clk,
   input  logic                 axi_resetn,
   input  logic                 start,
   input  logic                 continuous,
   input  logic                 halt_on_error,
   output logic                 busy,
   output logic                 done,
   output logic                 test_pass,
   output logic [ERR_BITS-1:0]  error_count,
   output logic [ERR_BITS-1:0]  iter_count,
   output logic [ADDR_BITS-1:0] fail_addr,
   output logic [DATA_BITS-1:0] fail_data,
   output logic [DATA_BITS-1:0] fail_expected,
   output logic [1:0]           pattern_idx,
   axi_sram_tester_master_if.master axi
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t               state;
   logic                 mode_cont, mode_halt, stop_q;
   logic                 awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q, b_wait;
   logic [ADDR_BITS-1:0] awaddr_q, araddr_q, addr_q;
   logic [DATA_BITS-1:0] wdata_q;
   logic [CNT_W-1:0]     outstanding, out_next;
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [ADDR_BITS-1:0] fifo_addr [MAX_OUTSTANDING];
   logic [DATA_BITS-1:0] fifo_exp  [MAX_OUTSTANDING];

   logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs, mismatch, halt_now;
   logic                 issue_wr;
   logic [ADDR_BITS-1:0] wr_addr_nxt;
   logic [1:0]           wr_p_nxt;
   logic                 unused_resp;

   function automatic logic [DATA_BITS-1:0] pattern(input logic [ADDR_BITS-1:0] a,
                                                    input logic [1:0] p);
      logic [DATA_BITS-1:0] base;
      if (p[1]) base = a[0] ? {(DATA_BITS/2){2'b10}} : {(DATA_BITS/2){2'b01}};
      else      base = DATA_BITS'(a);
      return p[0] ? ~base : base;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign axi.awaddr  = awaddr_q;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = '1;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;
   assign axi.araddr  = araddr_q;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;
   assign unused_resp = ^{axi.bresp, axi.rresp};

   assign aw_hs    = awvalid_q & axi.awready;
   assign w_hs     = wvalid_q & axi.wready;
   assign b_hs     = bready_q & axi.bvalid;
   assign ar_hs    = arvalid_q & axi.arready;
   // An R beat with nothing outstanding has no expected value; it is ignored.
   assign r_hs     = rready_q & axi.rvalid & (outstanding != '0);
   assign mismatch = r_hs & (axi.rdata != fifo_exp[rd_ptr]);
   // Halting reacts in the same cycle as the mismatch so no new AR is raised after it.
   assign halt_now = stop_q | (mode_halt & mismatch);

   always_comb begin
      out_next = outstanding;
      if (ar_hs && !r_hs)      out_next = outstanding + CNT_W'(1);
      else if (r_hs && !ar_hs) out_next = outstanding - CNT_W'(1);
   end

   // The first write of a phase is issued on the transition edge itself.
   always_comb begin
      issue_wr    = 1'b0;
      wr_addr_nxt = addr_q;
      wr_p_nxt    = pattern_idx;
      case (state)
         S_IDLE, S_DONE: begin
            issue_wr    = start;
            wr_addr_nxt = ADDR_MIN;
            wr_p_nxt    = 2'd0;
         end
         S_WRITE: issue_wr = !b_wait && !awvalid_q && !wvalid_q;
         S_DRAIN: begin
            issue_wr    = (outstanding == '0) && !stop_q && ((pattern_idx != 2'd3) || mode_cont);
            wr_addr_nxt = ADDR_MIN;
            wr_p_nxt    = pattern_idx + 2'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (ar_hs) begin
         fifo_addr[wr_ptr] <= araddr_q;
         fifo_exp[wr_ptr]  <= pattern(araddr_q, pattern_idx);
      end
   end

   always_ff @(posedge axi_clk) begin
      if (!axi_resetn) begin
         state         <= S_IDLE;
         mode_cont     <= 1'b0;
         mode_halt     <= 1'b0;
         stop_q        <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         bready_q      <= 1'b0;
         rready_q      <= 1'b0;
         b_wait        <= 1'b0;
         awaddr_q      <= '0;
         araddr_q      <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         outstanding   <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         test_pass     <= 1'b1;
         error_count   <= '0;
         iter_count    <= '0;
         fail_addr     <= '0;
         fail_data     <= '0;
         fail_expected <= '0;
         pattern_idx   <= 2'd0;
      end else begin
         bready_q    <= 1'b1;
         rready_q    <= 1'b1;
         outstanding <= out_next;
         if (aw_hs) awvalid_q <= 1'b0;
         if (w_hs)  wvalid_q  <= 1'b0;
         if (b_hs)  b_wait    <= 1'b0;
         if (ar_hs) wr_ptr    <= next_ptr(wr_ptr);
         if (r_hs)  rd_ptr    <= next_ptr(rd_ptr);

         if (mismatch) begin
            if (error_count != '1) error_count <= error_count + ERR_BITS'(1);
            if (test_pass) begin
               fail_addr     <= fifo_addr[rd_ptr];
               fail_data     <= axi.rdata;
               fail_expected <= fifo_exp[rd_ptr];
               test_pass     <= 1'b0;
            end
            if (mode_halt) stop_q <= 1'b1;
         end

         if (issue_wr) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            b_wait    <= 1'b1;
            awaddr_q  <= wr_addr_nxt;
            wdata_q   <= pattern(wr_addr_nxt, wr_p_nxt);
            addr_q    <= wr_addr_nxt + ADDR_BITS'(1);
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mode_cont     <= continuous;
                  mode_halt     <= halt_on_error;
                  stop_q        <= 1'b0;
                  error_count   <= '0;
                  iter_count    <= '0;
                  fail_addr     <= '0;
                  fail_data     <= '0;
                  fail_expected <= '0;
                  test_pass     <= 1'b1;
                  pattern_idx   <= 2'd0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  state         <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (b_hs && awaddr_q == ADDR_MAX) begin
                  addr_q <= ADDR_MIN;
                  state  <= S_READ;
               end
            end
            S_READ: begin
               // A raised arvalid is held until accepted; decisions happen only when it is free.
               if (!arvalid_q || ar_hs) begin
                  if ((ar_hs && araddr_q == ADDR_MAX) || halt_now) begin
                     arvalid_q <= 1'b0;
                     state     <= S_DRAIN;
                  end else if (out_next < MAX_CNT) begin
                     arvalid_q <= 1'b1;
                     araddr_q  <= addr_q;
                     addr_q    <= addr_q + ADDR_BITS'(1);
                  end else begin
                     arvalid_q <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               if (outstanding == '0) begin
                  if (stop_q) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     if (pattern_idx == 2'd3) iter_count <= iter_count + ERR_BITS'(1);
                     if (pattern_idx == 2'd3 && !mode_cont) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        pattern_idx <= wr_p_nxt;
                        state       <= S_WRITE;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_tester_master.sv
module tb_axi_sram_tester_master;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0, continuous = 1'b0, halt_on_error = 1'b0;
   logic        busy, done, test_pass;
   logic [15:0] error_count, iter_count;
   logic [19:0] fail_addr;
   logic [15:0] fail_data, fail_expected;
   logic [1:0]  pattern_idx;

   always #5 clk = ~clk;

   axi_sram_tester_master_if #(.ADDR_BITS(20), .DATA_BITS(16)) bus ();

   axi_sram_tester_master #(
      .ADDR_BITS(20), .DATA_BITS(16), .ADDR_MIN(20'd0), .ADDR_MAX(20'd7),
      .MAX_OUTSTANDING(4), .ERR_BITS(16)
   ) dut (
      .axi_clk(clk), .axi_resetn(rstn), .start(start), .continuous(continuous),
      .halt_on_error(halt_on_error), .busy(busy), .done(done), .test_pass(test_pass),
      .error_count(error_count), .iter_count(iter_count), .fail_addr(fail_addr),
      .fail_data(fail_data), .fail_expected(fail_expected), .pattern_idx(pattern_idx),
      .axi(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] pat(input int a, input int p);
      logic [15:0] b;
      b = (p >= 2) ? (((a % 2) == 1) ? 16'hAAAA : 16'h5555) : 16'(a);
      if ((p % 2) == 1) b = ~b;
      return b;
   endfunction

   // ---------------- slave model + monitors ----------------
   typedef struct {
      logic [15:0] data;
      int          due;
      bit          bad;
   } rsp_t;

   rsp_t        rq[$];
   bit          cfg_stall = 0, cfg_corrupt = 0;
   int          cfg_rdelay = 0;
   int          cyc = 0;
   bit          aw_got, w_got, b_pend, mm_seen;
   bit          hold_aw, hold_w, hold_ar;
   int          b_cnt;
   logic [19:0] aw_a;
   logic [15:0] w_d;
   logic [15:0] mem [8];
   int          wr_idx, rd_idx, wr_bad, rd_bad, mon_out, max_out;
   int          hold_bad, out_bad, halt_bad;
   bit          prev_arv;

   always @(posedge clk) begin
      logic [15:0] d;
      bit          bad;
      cyc++;
      if (!rstn) begin
         bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
         bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rdata  <= '0;   bus.rresp <= 2'b00;
         rq.delete();
         aw_got = 0; w_got = 0; b_pend = 0; b_cnt = 0; mm_seen = 0;
         hold_aw = 0; hold_w = 0; hold_ar = 0;
         wr_idx = 0; rd_idx = 0; wr_bad = 0; rd_bad = 0; mon_out = 0; max_out = 0;
      end else begin
         hold_aw = bus.awvalid && !bus.awready;
         hold_w  = bus.wvalid && !bus.wready;
         hold_ar = bus.arvalid && !bus.arready;
         if (bus.awvalid && bus.awready) begin aw_got = 1; aw_a = bus.awaddr; end
         if (bus.wvalid && bus.wready)   begin w_got = 1;  w_d = bus.wdata;   end
         if (aw_got && w_got) begin
            if (aw_a != 20'(wr_idx % 8) || w_d != pat(wr_idx % 8, (wr_idx / 8) % 4)) wr_bad++;
            mem[aw_a[2:0]] = w_d;
            wr_idx++;
            aw_got = 0; w_got = 0; b_pend = 1;
            b_cnt = cfg_stall ? int'($urandom_range(0, 3)) : 0;
         end
         if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
         else if (b_pend && !bus.bvalid) begin
            if (b_cnt == 0) begin bus.bvalid <= 1'b1; b_pend = 0; end
            else b_cnt--;
         end

         if (bus.rvalid && bus.rready) begin
            if (rq[0].bad) mm_seen = 1;
            void'(rq.pop_front());
            mon_out--;
         end
         if (bus.arvalid && bus.arready) begin
            if (bus.araddr != 20'(rd_idx % 8)) rd_bad++;
            rd_idx++;
            d = mem[bus.araddr[2:0]];
            bad = cfg_corrupt && bus.araddr == 20'd5 && d == 16'hFFFA;
            if (bad) d = 16'h0000;
            rq.push_back('{d, cyc + cfg_rdelay + (cfg_stall ? int'($urandom_range(0, 3)) : 0), bad});
            mon_out++;
            if (mon_out > max_out) max_out = mon_out;
         end
         if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
         else if (!bus.rvalid && rq.size() > 0 && rq[0].due <= cyc) begin
            bus.rvalid <= 1'b1;
            bus.rdata  <= rq[0].data;
         end

         bus.awready <= cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.wready  <= cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.arready <= cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rstn) begin
         hold_bad = 0; out_bad = 0; halt_bad = 0; prev_arv = 0;
      end else begin
         if ((hold_aw && !bus.awvalid) || (hold_w && !bus.wvalid) || (hold_ar && !bus.arvalid))
            hold_bad++;
         if (mon_out >= 4 && bus.arvalid) out_bad++;
         if (mm_seen && halt_on_error && bus.arvalid && !prev_arv) halt_bad++;
         prev_arv = bus.arvalid;
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      string name;
      bit    halt, stall, corrupt;
      int    rdelay;
      int    err, iter;
      bit    pass;
      int    faddr, fdata, fexp, nwr, nrd, maxo;
   } vec_t;

   vec_t vecs[5];

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
      check({name, ".done"}, done, 1);
   endtask

   initial begin
      //           name     halt st cor dly err it pass fa fd  fe      nwr nrd maxo
      vecs[0] = '{"ideal",   0, 0, 0,  0,  0, 1, 1,  0, 0, 0,       32, 32, -1};
      vecs[1] = '{"corrupt", 0, 0, 1,  0,  1, 1, 0,  5, 0, 'hFFFA,  32, 32, -1};
      vecs[2] = '{"halt",    1, 0, 1,  0,  1, 0, 0,  5, 0, 'hFFFA,  16, -1, -1};
      vecs[3] = '{"slow_r",  0, 0, 0, 10,  0, 1, 1,  0, 0, 0,       32, 32,  4};
      vecs[4] = '{"stalls",  0, 1, 0,  0,  0, 1, 1,  0, 0, 0,       32, 32, -1};

      repeat (3) @(negedge clk);
      check("rst.bready", bus.bready, 0);
      check("rst.rready", bus.rready, 0);
      rstn = 1'b1;
      @(negedge clk);
      check("rst.bready_after", bus.bready, 1);
      check("rst.rready_after", bus.rready, 1);
      check("rst.valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
      check("rst.status", {busy, done, test_pass}, 3'b001);
      check("rst.counts", {error_count, iter_count}, 0);
      check("rst.pattern", pattern_idx, 0);
      check("rst.fail_addr", fail_addr, 0);
      check("wstrb", bus.wstrb, 2'b11);

      for (int i = 0; i < 5; i++) begin
         rstn = 1'b0;
         cfg_stall = vecs[i].stall; cfg_corrupt = vecs[i].corrupt; cfg_rdelay = vecs[i].rdelay;
         halt_on_error = vecs[i].halt; continuous = 1'b0;
         repeat (2) @(negedge clk);
         rstn = 1'b1;
         @(negedge clk);
         pulse_start();
         check({vecs[i].name, ".first_aw"}, {bus.awvalid, bus.wvalid, busy}, 3'b111);
         check({vecs[i].name, ".first_addr"}, bus.awaddr, 0);
         check({vecs[i].name, ".first_data"}, bus.wdata, pat(0, 0));
         wait_done(vecs[i].name);
         check({vecs[i].name, ".busy"}, busy, 0);
         check({vecs[i].name, ".pass"}, test_pass, vecs[i].pass);
         check({vecs[i].name, ".err"}, error_count, vecs[i].err);
         check({vecs[i].name, ".iter"}, iter_count, vecs[i].iter);
         check({vecs[i].name, ".fail_addr"}, fail_addr, vecs[i].faddr);
         check({vecs[i].name, ".fail_data"}, fail_data, vecs[i].fdata);
         check({vecs[i].name, ".fail_exp"}, fail_expected, vecs[i].fexp);
         check({vecs[i].name, ".wr_order"}, wr_bad, 0);
         check({vecs[i].name, ".rd_order"}, rd_bad, 0);
         check({vecs[i].name, ".hold"}, hold_bad, 0);
         check({vecs[i].name, ".out_limit"}, out_bad, 0);
         check({vecs[i].name, ".halt_ar"}, halt_bad, 0);
         check({vecs[i].name, ".outstanding"}, mon_out, 0);
         if (vecs[i].nwr >= 0)  check({vecs[i].name, ".n_wr"}, wr_idx, vecs[i].nwr);
         if (vecs[i].nrd >= 0)  check({vecs[i].name, ".n_rd"}, rd_idx, vecs[i].nrd);
         if (vecs[i].maxo >= 0) check({vecs[i].name, ".max_out"}, max_out, vecs[i].maxo);
      end

      // Continuous run, reset for one cycle in the middle of a READ phase.
      rstn = 1'b0;
      cfg_stall = 0; cfg_corrupt = 0; cfg_rdelay = 0; halt_on_error = 1'b0; continuous = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      pulse_start();
      begin
         int k;
         for (k = 0; k < 20000 && !(iter_count == 16'd1 && bus.arvalid); k++) @(negedge clk);
         check("cont.reach_iter1_read", {iter_count == 16'd1, bus.arvalid}, 2'b11);
      end
      check("cont.busy", busy, 1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check("midrst.valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
      check("midrst.readies", {bus.bready, bus.rready}, 0);
      check("midrst.status", {busy, done, test_pass}, 3'b001);
      check("midrst.counts", {error_count, iter_count}, 0);
      check("midrst.pattern", pattern_idx, 0);
      continuous = 1'b0;
      @(negedge clk);
      pulse_start();
      wait_done("rerun");
      check("rerun.pass", test_pass, 1);
      check("rerun.err", error_count, 0);
      check("rerun.iter", iter_count, 1);
      check("rerun.n_wr", wr_idx, 32);
      check("rerun.n_rd", rd_idx, 32);
      check("rerun.order", wr_bad + rd_bad, 0);

      // Restart straight from DONE without a reset.
      pulse_start();
      check("restart.busy_done", {busy, done}, 2'b10);
      wait_done("restart");
      check("restart.iter", iter_count, 1);
      check("restart.pass", test_pass, 1);
      check("restart.n_rd", rd_idx, 64);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
